// File: rtl/aec_pkg.sv
// Shared types and ASCII constants for the AEC transmit side.
package aec_pkg;

  typedef enum logic [2:0] {
    TK_DIG = 3'd0,
    TK_ADD = 3'd1,
    TK_SUB = 3'd2,
    TK_MUL = 3'd3,
    TK_LP  = 3'd4,
    TK_RP  = 3'd5
  } tok_kind_e;

  localparam logic [7:0] ASC_0   = 8'd48;
  localparam logic [7:0] ASC_A   = 8'd97;
  localparam logic [7:0] ASC_ADD = 8'd43;
  localparam logic [7:0] ASC_SUB = 8'd45;
  localparam logic [7:0] ASC_MUL = 8'd42;
  localparam logic [7:0] ASC_LP  = 8'd40;
  localparam logic [7:0] ASC_RP  = 8'd41;
  localparam logic [7:0] ASC_EQ  = 8'd61;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } state_e;

endpackage

// File: rtl/aec_expr_tx_if.sv
// Host-side token load and result return bus of aec_expr_tx.
interface aec_expr_tx_if;
  logic       tok_valid;
  logic       tok_ready;
  logic [2:0] tok_kind;
  logic [3:0] tok_val;
  logic       tok_last;
  logic       res_valid;
  logic [6:0] res_data;
  logic       res_timeout;
  logic [1:0] err_flags;
  logic       busy;

  modport master (
    output tok_valid, tok_kind, tok_val, tok_last,
    input  tok_ready, res_valid, res_data, res_timeout, err_flags, busy
  );

  modport slave (
    input  tok_valid, tok_kind, tok_val, tok_last,
    output tok_ready, res_valid, res_data, res_timeout, err_flags, busy
  );
endinterface

// File: rtl/aec_tok2ascii.sv
// Combinational token-to-ASCII mapper; kinds 6 and 7 raise illegal.
module aec_tok2ascii
  import aec_pkg::*;
(
  input  logic [2:0] kind,
  input  logic [3:0] val,
  output logic [7:0] ascii,
  output logic       illegal
);

  always_comb begin
    ascii   = '0;
    illegal = 1'b0;
    case (kind)
      TK_DIG:  ascii = (val < 4'd10) ? ASC_0 + {4'b0, val}
                                     : ASC_A + {4'b0, val} - 8'd10;
      TK_ADD:  ascii = ASC_ADD;
      TK_SUB:  ascii = ASC_SUB;
      TK_MUL:  ascii = ASC_MUL;
      TK_LP:   ascii = ASC_LP;
      TK_RP:   ascii = ASC_RP;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/aec_expr_tx.sv
// Buffers a host token expression, streams it to the AEC as ASCII ending in '=',
// then returns the AEC result (or a timeout) to the host.
module aec_expr_tx
  import aec_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned GAP     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  aec_expr_tx_if.slave     host,
  output logic [7:0]       ascii_out,
  output logic             aec_ready,
  input  logic             aec_valid,
  input  logic [6:0]       aec_result
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  state_e        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] idx;
  logic [TW-1:0] timer;
  logic          first;
  logic [7:0]    buffer [DEPTH];

  logic [7:0]    asc;
  logic          illegal;
  logic          accept;
  logic          store;
  logic          full;
  logic          go_send;
  logic [7:0]    first_char;
  logic [1:0]    err_base;
  logic [CW-1:0] idx_n;

  aec_tok2ascii u_map (
    .kind    (host.tok_kind),
    .val     (host.tok_val),
    .ascii   (asc),
    .illegal (illegal)
  );

  // The first SEND character is registered on the same edge that may write buffer[0].
  always_comb begin
    accept     = (state == LOAD) && host.tok_valid;
    store      = accept && !illegal;
    full       = (cnt == CW'(DEPTH - 1));
    go_send    = (store && (host.tok_last || full)) ||
                 (accept && illegal && host.tok_last && (cnt != '0));
    first_char = (cnt == '0) ? asc : buffer[0];
    err_base   = first ? '0 : host.err_flags;
    idx_n      = idx + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (store) buffer[cnt[AW-1:0]] <= asc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= LOAD;
      cnt              <= '0;
      idx              <= '0;
      timer            <= '0;
      first            <= 1'b1;
      ascii_out        <= '0;
      aec_ready        <= 1'b0;
      host.tok_ready   <= 1'b1;
      host.res_valid   <= 1'b0;
      host.res_data    <= '0;
      host.res_timeout <= 1'b0;
      host.err_flags   <= '0;
      host.busy        <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            first          <= 1'b0;
            host.err_flags <= err_base | {illegal, store && full && !host.tok_last};
            if (store) cnt <= cnt + CW'(1);
            if (go_send) begin
              state          <= SEND;
              idx            <= '0;
              ascii_out      <= first_char;
              aec_ready      <= 1'b1;
              host.tok_ready <= 1'b0;
              host.busy      <= 1'b1;
            end
          end
        end
        SEND: begin
          aec_ready <= 1'b0;
          if (idx == cnt) begin
            ascii_out <= '0;
            timer     <= '0;
            state     <= WAIT;
          end else if (idx == cnt - CW'(1)) begin
            ascii_out <= ASC_EQ;
            idx       <= cnt;
          end else begin
            ascii_out <= buffer[idx_n[AW-1:0]];
            idx       <= idx_n;
          end
        end
        WAIT: begin
          if (aec_valid) begin
            host.res_data    <= aec_result;
            host.res_timeout <= 1'b0;
            host.res_valid   <= 1'b1;
            timer            <= '0;
            state            <= aec_pkg::GAP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            host.res_data    <= '0;
            host.res_timeout <= 1'b1;
            host.res_valid   <= 1'b1;
            timer            <= '0;
            state            <= aec_pkg::GAP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        aec_pkg::GAP: begin
          host.res_valid <= 1'b0;
          if (timer == TW'(GAP - 1)) begin
            cnt            <= '0;
            first          <= 1'b1;
            host.tok_ready <= 1'b1;
            host.busy      <= 1'b0;
            state          <= LOAD;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
